// File: rtl/usb_uart_pkg.sv
// Shared constants and state encoding for the USB UART line buffer.
package usb_uart_pkg;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_A_LO = 8'h61;
  localparam logic [7:0] ASCII_Z_LO = 8'h7A;
  localparam logic [7:0] CASE_DELTA = 8'h20;

  typedef enum logic {
    LB_FILL  = 1'b0,
    LB_DRAIN = 1'b1
  } lb_state_e;

endpackage

// File: rtl/usb_uart_byte_ram.sv
// DEPTH x 8 simple dual-port RAM, registered read; maps onto iCE40 EBR.
module usb_uart_byte_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_48mhz,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    q
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk_48mhz) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/usb_uart_line_buffer.sv
// Line-assembling echo buffer between usb_uart RX and TX byte streams.
// Optional build macro USB_UART_LINE_UPCASE_EN uppercases a..z on write.
module usb_uart_line_buffer
  import usb_uart_pkg::*;
#(
  parameter int DEPTH          = 64,
  parameter int TIMEOUT_CYCLES = 4_800_000
) (
  input  logic                       clk_48mhz,
  input  logic                       reset,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [7:0]                 out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] line_count,
  output logic                       overflow,
  output logic                       timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  lb_state_e     state;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fetch_left;
  logic [IW-1:0] idle_cnt;
  logic          rd_pend, skid_valid;
  logic [7:0]    skid_data, ram_q, wr_byte;
  logic [1:0]    held;
  logic          in_fire, out_fire, is_term, last_slot, issue;

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign is_term   = (in_data == ASCII_CR) || (in_data == ASCII_LF);
  assign last_slot = (line_count == CW'(DEPTH - 1));

  // Bytes in out/skid after this edge; one more read may be in flight only if a slot stays free.
  assign held  = 2'(out_valid) + 2'(skid_valid) + 2'(rd_pend) - 2'(out_fire);
  assign issue = (state == LB_DRAIN) && (fetch_left != '0) && (held <= 2'd1);

`ifdef USB_UART_LINE_UPCASE_EN
  assign wr_byte = (in_data >= ASCII_A_LO && in_data <= ASCII_Z_LO) ? in_data - CASE_DELTA : in_data;
`else
  assign wr_byte = in_data;
`endif

  usb_uart_byte_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk_48mhz (clk_48mhz),
    .we        (in_fire),
    .waddr     (wr_ptr),
    .wdata     (wr_byte),
    .re        (issue),
    .raddr     (rd_ptr),
    .q         (ram_q)
  );

  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      state      <= LB_FILL;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fetch_left <= '0;
      idle_cnt   <= '0;
      line_count <= '0;
      in_ready   <= 1'b0;
      overflow   <= 1'b0;
      timeout    <= 1'b0;
      rd_pend    <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      overflow <= 1'b0;
      timeout  <= 1'b0;
      case (state)
        LB_FILL: begin
          in_ready <= 1'b1;
          if (in_fire) begin
            wr_ptr     <= wr_ptr + 1'b1;
            line_count <= line_count + 1'b1;
            idle_cnt   <= '0;
            if (is_term || last_slot) begin
              state      <= LB_DRAIN;
              in_ready   <= 1'b0;
              fetch_left <= line_count + 1'b1;
              overflow   <= !is_term;
            end
          end else if (TIMEOUT_CYCLES != 0 && idle_cnt != IW'(TIMEOUT_CYCLES)) begin
            // Saturates at the limit so an empty buffer never wraps into a late timeout.
            idle_cnt <= idle_cnt + 1'b1;
            if (idle_cnt == IW'(TIMEOUT_CYCLES - 1) && line_count != '0) begin
              state      <= LB_DRAIN;
              in_ready   <= 1'b0;
              fetch_left <= line_count;
              timeout    <= 1'b1;
            end
          end
        end
        LB_DRAIN: begin
          in_ready <= 1'b0;
          if (issue) begin
            rd_ptr     <= rd_ptr + 1'b1;
            fetch_left <= fetch_left - 1'b1;
          end
          if (out_fire) begin
            line_count <= line_count - 1'b1;
            if (line_count == CW'(1)) begin
              state    <= LB_FILL;
              in_ready <= 1'b1;
              idle_cnt <= '0;
            end
          end
        end
        default: state <= LB_FILL;
      endcase

      // Output register with one-entry skid to absorb the read in flight during a stall.
      rd_pend <= issue;
      if (out_valid && !out_ready) begin
        if (rd_pend) begin
          skid_valid <= 1'b1;
          skid_data  <= ram_q;
        end
      end else if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= rd_pend;
        if (rd_pend) skid_data <= ram_q;
      end else begin
        out_valid <= rd_pend;
        if (rd_pend) out_data <= ram_q;
      end
    end
  end

endmodule

// File: tb/tb_usb_uart_line_buffer.sv
// Self-checking bench for usb_uart_line_buffer: directed scenarios plus random lines vs a queue model.
module tb_usb_uart_line_buffer;

  localparam int DEPTH = 64;
  localparam int TO    = 100;

  logic       clk_48mhz = 1'b0;
  logic       reset     = 1'b1;
  logic [7:0] in_data   = 8'h00;
  logic       in_valid  = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [6:0] line_count;
  logic       overflow, timeout;

  usb_uart_line_buffer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk_48mhz  (clk_48mhz),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .line_count (line_count),
    .overflow   (overflow),
    .timeout    (timeout)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  int         checks   = 0;
  int         errors   = 0;
  int         rx_total = 0;
  int         ovf_cnt  = 0;
  int         to_cnt   = 0;
  bit         rand_rdy = 1'b0;
  logic [7:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: each accepted byte comes back once, in order, optionally uppercased.
  function automatic logic [7:0] model_byte(input logic [7:0] b);
`ifdef USB_UART_LINE_UPCASE_EN
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
    return b;
  endfunction

  task automatic step();
    @(posedge clk_48mhz);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bit ok;
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    exp_q.push_back(model_byte(b));
    do begin
      ok = in_ready;
      step();
      n++;
    end while (!ok && n < 3000);
    in_valid = 1'b0;
    chk("send_accept", 32'(ok), 1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic wait_drain(input string tag);
    bit done;
    int n;
    n = 0;
    done = 1'b0;
    while (!done && n < 5000) begin
      done = in_ready && (line_count == 7'd0) && !out_valid;
      if (!done) step();
      n++;
    end
    chk({tag, "_drained"}, 32'(done), 1);
    chk({tag, "_all_out"}, exp_q.size(), 0);
  endtask

  always @(posedge clk_48mhz) begin
    #1;
    out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: scoreboard compare, stall stability, pulse bookkeeping.
  always @(negedge clk_48mhz) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        logic [31:0] e;
        e = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hFFFF_FFFF;
        rx_total++;
        chk("out_byte", 32'(out_data), e);
      end
      if (overflow) ovf_cnt++;
      if (timeout) to_cnt++;
      if (overflow || timeout) chk("pulse_excl", 32'(overflow & timeout), 0);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    int base, n, len;

    // Reset state and release
    repeat (3) @(posedge clk_48mhz);
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_line_count", 32'(line_count), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_timeout", 32'(timeout), 0);
    reset = 1'b0;
    step();
    chk("rel_in_ready", 32'(in_ready), 1);

    // T1 line echo with exact latency
    send_str("AB\r");
    chk("t1_in_ready_drain", 32'(in_ready), 0);
    chk("t1_valid_e1", 32'(out_valid), 0);
    step();
    chk("t1_valid_e2", 32'(out_valid), 0);
    step();
    chk("t1_valid_rise", 32'(out_valid), 1);
    chk("t1_first_byte", 32'(out_data), 32'h41);
    wait_drain("t1");

    // Back-to-back: one byte per cycle with out_ready held high
    send_str("abcdef\r");
    step();
    step();
    for (int i = 0; i < 7; i++) begin
      chk("b2b_valid", 32'(out_valid), 1);
      chk("b2b_in_ready", 32'(in_ready), 0);
      step();
    end
    chk("b2b_end", 32'(out_valid), 0);
    wait_drain("b2b");

    // T2 overflow
    base = ovf_cnt;
    for (int i = 0; i < DEPTH - 1; i++) send(8'h55);
    chk("t2_no_early_ovf", ovf_cnt - base, 0);
    send(8'h55);
    chk("t2_overflow", 32'(overflow), 1);
    chk("t2_in_ready", 32'(in_ready), 0);
    chk("t2_count_full", 32'(line_count), DEPTH);
    wait_drain("t2");
    chk("t2_ovf_pulses", ovf_cnt - base, 1);

    // T3 idle timeout
    base = to_cnt;
    send_str("xy");
    for (int i = 1; i <= TO; i++) begin
      step();
      if (i == TO - 1) chk("t3_no_early_to", 32'(timeout), 0);
      if (i == TO) chk("t3_timeout", 32'(timeout), 1);
    end
    wait_drain("t3");
    chk("t3_to_pulses", to_cnt - base, 1);
    base = to_cnt;
    repeat (1000) step();
    chk("t3_empty_no_to", to_cnt - base, 0);
    chk("t3_empty_count", 32'(line_count), 0);

    // T4 back-pressure with random out_ready, then random lines
    rand_rdy = 1'b1;
    send_str("hello\n");
    wait_drain("t4");
    for (int l = 0; l < 6; l++) begin
      len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++) send(8'($urandom_range(32, 126)));
      send(($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A);
      wait_drain("rand_line");
    end
    rand_rdy = 1'b0;
    step();

    // T5 reset during drain after 2 of 6 bytes
    send_str("abcde\r");
    base = rx_total;
    n = 0;
    while (rx_total < base + 2 && n < 200) begin
      @(negedge clk_48mhz);
      n++;
    end
    chk("t5_two_out", rx_total - base, 2);
    @(posedge clk_48mhz);
    #1;
    reset = 1'b1;
    #1;
    chk("t5_out_valid", 32'(out_valid), 0);
    chk("t5_out_data", 32'(out_data), 0);
    chk("t5_line_count", 32'(line_count), 0);
    chk("t5_in_ready", 32'(in_ready), 0);
    exp_q.delete();
    step();
    reset = 1'b0;
    step();
    chk("t5_rel_in_ready", 32'(in_ready), 1);
    send_str("z\r");
    wait_drain("t5");

    // T6 case mapping and CRLF as two lines
    send_str("aZ{\r");
    wait_drain("t6");
    send_str("ok\r");
    chk("crlf_cr_count", 32'(line_count), 3);
    chk("crlf_cr_hold", 32'(in_ready), 0);
    send(8'h0A);
    chk("crlf_lf_count", 32'(line_count), 1);
    chk("crlf_lf_drain", 32'(in_ready), 0);
    wait_drain("crlf");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
